// File: rtl/matrix_slot_manager_pkg.sv
// Shared constants for the matrix slot manager: slot states, error codes, table size.
package matrix_slot_manager_pkg;

    localparam int NUM_SLOTS = 16;

    localparam logic [1:0] SLOT_FREE     = 2'd0;
    localparam logic [1:0] SLOT_RESERVED = 2'd1;
    localparam logic [1:0] SLOT_VALID    = 2'd2;

    localparam logic [3:0] ERR_NONE       = 4'd0;
    localparam logic [3:0] ERR_MEM_FULL   = 4'd1;
    localparam logic [3:0] ERR_BAD_COMMIT = 4'd2;

    // 16x16 = 256 is the largest product, so 9 bits always hold it.
    function automatic logic [8:0] dim_elems(input logic [4:0] m, input logic [4:0] n);
        return 9'(m) * 9'(n);
    endfunction

endpackage

// File: rtl/matrix_slot_manager.sv
// Responder for matrix alloc/commit: owns the slot table and the BRAM bump pointer,
// grants fresh storage or recycles the oldest same-dimension slot.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE      | applies pending/new commits, accepts an alloc request
// SCAN      | walks slots 0..15, one per cycle, gathering statistics
// DECIDE    | reuse oldest, reserve a free slot, or refuse
// GRANT     | alloc_valid pulse is visible
// FAIL_HOLD | refusal issued, waiting for alloc_req to drop
module matrix_slot_manager
    import matrix_slot_manager_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int MEM_DEPTH  = 2048,
    parameter int SEQ_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            config_max_per_dim,
    input  logic                  alloc_req,
    input  logic [4:0]            alloc_m,
    input  logic [4:0]            alloc_n,
    output logic                  alloc_valid,
    output logic                  alloc_fail,
    output logic [3:0]            alloc_slot,
    output logic [ADDR_WIDTH-1:0] alloc_addr,
    input  logic                  commit_req,
    input  logic [3:0]            commit_slot,
    input  logic [4:0]            commit_m,
    input  logic [4:0]            commit_n,
    input  logic [ADDR_WIDTH-1:0] commit_addr,
    input  logic                  clear_all,
    input  logic [3:0]            rd_slot,
    output logic                  rd_valid,
    output logic [4:0]            rd_m,
    output logic [4:0]            rd_n,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [4:0]            slot_count,
    output logic [ADDR_WIDTH:0]   free_words,
    output logic [3:0]            error_code
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SCAN      = 3'd1;
    localparam logic [2:0] ST_DECIDE    = 3'd2;
    localparam logic [2:0] ST_GRANT     = 3'd3;
    localparam logic [2:0] ST_FAIL_HOLD = 3'd4;

    localparam int              BW        = ADDR_WIDTH + 1;
    localparam logic [BW:0]     DEPTH_EXT = (BW + 1)'(MEM_DEPTH);
    localparam logic [BW-1:0]   DEPTH_W   = BW'(MEM_DEPTH);

    logic [2:0]            state_q, state_d;
    logic [1:0]            slot_state_q [NUM_SLOTS];
    logic [1:0]            slot_state_d [NUM_SLOTS];
    logic [4:0]            slot_m_q     [NUM_SLOTS];
    logic [4:0]            slot_m_d     [NUM_SLOTS];
    logic [4:0]            slot_n_q     [NUM_SLOTS];
    logic [4:0]            slot_n_d     [NUM_SLOTS];
    logic [ADDR_WIDTH-1:0] slot_addr_q  [NUM_SLOTS];
    logic [ADDR_WIDTH-1:0] slot_addr_d  [NUM_SLOTS];
    logic [SEQ_WIDTH-1:0]  slot_stamp_q [NUM_SLOTS];
    logic [SEQ_WIDTH-1:0]  slot_stamp_d [NUM_SLOTS];

    logic [BW-1:0]         bump_q, bump_d;
    logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
    logic [4:0]            req_m_q, req_m_d, req_n_q, req_n_d;
    logic [8:0]            elems_q, elems_d;
    logic [3:0]            scan_idx_q, scan_idx_d;
    logic [4:0]            same_cnt_q, same_cnt_d;
    logic [3:0]            oldest_idx_q, oldest_idx_d;
    logic [SEQ_WIDTH-1:0]  oldest_age_q, oldest_age_d;
    logic                  oldest_found_q, oldest_found_d;
    logic [3:0]            free_idx_q, free_idx_d;
    logic                  free_found_q, free_found_d;

    logic                  pend_q, pend_d;
    logic [3:0]            pend_slot_q, pend_slot_d;
    logic [4:0]            pend_m_q, pend_m_d, pend_n_q, pend_n_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;

    logic                  alloc_valid_q, alloc_valid_d, alloc_fail_q, alloc_fail_d;
    logic [3:0]            alloc_slot_q, alloc_slot_d;
    logic [ADDR_WIDTH-1:0] alloc_addr_q, alloc_addr_d;
    logic [3:0]            err_q, err_d;

    logic                  rd_valid_q;
    logic [4:0]            rd_m_q, rd_n_q, slot_count_q, valid_cnt;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [BW-1:0]         free_words_q;

    logic                  cm_en;
    logic [3:0]            cm_slot;
    logic [4:0]            cm_m, cm_n;
    logic [ADDR_WIDTH-1:0] cm_addr;
    logic [SEQ_WIDTH-1:0]  age;
    logic [BW:0]           sum;

    always_comb begin
        state_d        = state_q;
        slot_state_d   = slot_state_q;
        slot_m_d       = slot_m_q;
        slot_n_d       = slot_n_q;
        slot_addr_d    = slot_addr_q;
        slot_stamp_d   = slot_stamp_q;
        bump_d         = bump_q;
        seq_d          = seq_q;
        req_m_d        = req_m_q;
        req_n_d        = req_n_q;
        elems_d        = elems_q;
        scan_idx_d     = scan_idx_q;
        same_cnt_d     = same_cnt_q;
        oldest_idx_d   = oldest_idx_q;
        oldest_age_d   = oldest_age_q;
        oldest_found_d = oldest_found_q;
        free_idx_d     = free_idx_q;
        free_found_d   = free_found_q;
        pend_d         = pend_q;
        pend_slot_d    = pend_slot_q;
        pend_m_d       = pend_m_q;
        pend_n_d       = pend_n_q;
        pend_addr_d    = pend_addr_q;
        alloc_valid_d  = 1'b0;
        alloc_fail_d   = 1'b0;
        alloc_slot_d   = alloc_slot_q;
        alloc_addr_d   = alloc_addr_q;
        err_d          = err_q;
        cm_en          = 1'b0;
        cm_slot        = pend_slot_q;
        cm_m           = pend_m_q;
        cm_n           = pend_n_q;
        cm_addr        = pend_addr_q;
        age            = seq_q - slot_stamp_q[scan_idx_q];
        sum            = {1'b0, bump_q} + (BW + 1)'(elems_q);

        case (state_q)
            ST_IDLE: begin
                // A deferred commit always lands before a new alloc is accepted.
                if (pend_q) begin
                    cm_en  = 1'b1;
                    pend_d = commit_req;
                    if (commit_req) begin
                        pend_slot_d = commit_slot;
                        pend_m_d    = commit_m;
                        pend_n_d    = commit_n;
                        pend_addr_d = commit_addr;
                    end
                end else if (commit_req) begin
                    cm_en   = 1'b1;
                    cm_slot = commit_slot;
                    cm_m    = commit_m;
                    cm_n    = commit_n;
                    cm_addr = commit_addr;
                end else if (alloc_req) begin
                    state_d        = ST_SCAN;
                    req_m_d        = alloc_m;
                    req_n_d        = alloc_n;
                    elems_d        = dim_elems(alloc_m, alloc_n);
                    scan_idx_d     = 4'd0;
                    same_cnt_d     = 5'd0;
                    oldest_idx_d   = 4'd0;
                    oldest_age_d   = '0;
                    oldest_found_d = 1'b0;
                    free_idx_d     = 4'd0;
                    free_found_d   = 1'b0;
                end
            end
            ST_SCAN: begin
                if (slot_state_q[scan_idx_q] == SLOT_VALID &&
                    slot_m_q[scan_idx_q] == req_m_q && slot_n_q[scan_idx_q] == req_n_q) begin
                    same_cnt_d = same_cnt_q + 5'd1;
                    if (!oldest_found_q || age > oldest_age_q) begin
                        oldest_found_d = 1'b1;
                        oldest_idx_d   = scan_idx_q;
                        oldest_age_d   = age;
                    end
                end
                if (slot_state_q[scan_idx_q] == SLOT_FREE && !free_found_q) begin
                    free_found_d = 1'b1;
                    free_idx_d   = scan_idx_q;
                end
                scan_idx_d = scan_idx_q + 4'd1;
                if (scan_idx_q == 4'd15) state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (config_max_per_dim != 3'd0 && same_cnt_q >= {2'b00, config_max_per_dim}) begin
                    slot_state_d[oldest_idx_q] = SLOT_RESERVED;
                    alloc_slot_d  = oldest_idx_q;
                    alloc_addr_d  = slot_addr_q[oldest_idx_q];
                    alloc_valid_d = 1'b1;
                    err_d         = ERR_NONE;
                    state_d       = ST_GRANT;
                end else if (free_found_q && sum <= DEPTH_EXT) begin
                    slot_state_d[free_idx_q] = SLOT_RESERVED;
                    slot_addr_d[free_idx_q]  = bump_q[ADDR_WIDTH-1:0];
                    bump_d        = sum[BW-1:0];
                    alloc_slot_d  = free_idx_q;
                    alloc_addr_d  = bump_q[ADDR_WIDTH-1:0];
                    alloc_valid_d = 1'b1;
                    err_d         = ERR_NONE;
                    state_d       = ST_GRANT;
                end else begin
                    alloc_fail_d = 1'b1;
                    err_d        = ERR_MEM_FULL;
                    state_d      = ST_FAIL_HOLD;
                end
            end
            ST_GRANT:     state_d = ST_IDLE;
            ST_FAIL_HOLD: if (!alloc_req) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        if (commit_req && state_q != ST_IDLE) begin
            if (pend_q) begin
                err_d = ERR_BAD_COMMIT;
            end else begin
                pend_d      = 1'b1;
                pend_slot_d = commit_slot;
                pend_m_d    = commit_m;
                pend_n_d    = commit_n;
                pend_addr_d = commit_addr;
            end
        end

        if (cm_en) begin
            if (slot_state_q[cm_slot] == SLOT_RESERVED) begin
                slot_state_d[cm_slot] = SLOT_VALID;
                slot_m_d[cm_slot]     = cm_m;
                slot_n_d[cm_slot]     = cm_n;
                slot_addr_d[cm_slot]  = cm_addr;
                slot_stamp_d[cm_slot] = seq_q;
                seq_d                 = seq_q + 1'b1;
            end else begin
                err_d = ERR_BAD_COMMIT;
            end
        end

        if (clear_all) begin
            state_d = ST_IDLE;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_state_d[i] = SLOT_FREE;
                slot_m_d[i]     = '0;
                slot_n_d[i]     = '0;
                slot_addr_d[i]  = '0;
                slot_stamp_d[i] = '0;
            end
            bump_d        = '0;
            seq_d         = '0;
            pend_d        = 1'b0;
            alloc_valid_d = 1'b0;
            alloc_fail_d  = 1'b0;
            alloc_slot_d  = '0;
            alloc_addr_d  = '0;
            err_d         = ERR_NONE;
        end
    end

    always_comb begin
        valid_cnt = 5'd0;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (slot_state_q[i] == SLOT_VALID) valid_cnt = valid_cnt + 5'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_state_q[i] <= SLOT_FREE;
                slot_m_q[i]     <= '0;
                slot_n_q[i]     <= '0;
                slot_addr_q[i]  <= '0;
                slot_stamp_q[i] <= '0;
            end
            bump_q         <= '0;
            seq_q          <= '0;
            req_m_q        <= '0;
            req_n_q        <= '0;
            elems_q        <= '0;
            scan_idx_q     <= '0;
            same_cnt_q     <= '0;
            oldest_idx_q   <= '0;
            oldest_age_q   <= '0;
            oldest_found_q <= 1'b0;
            free_idx_q     <= '0;
            free_found_q   <= 1'b0;
            pend_q         <= 1'b0;
            pend_slot_q    <= '0;
            pend_m_q       <= '0;
            pend_n_q       <= '0;
            pend_addr_q    <= '0;
            alloc_valid_q  <= 1'b0;
            alloc_fail_q   <= 1'b0;
            alloc_slot_q   <= '0;
            alloc_addr_q   <= '0;
            err_q          <= ERR_NONE;
        end else begin
            state_q        <= state_d;
            slot_state_q   <= slot_state_d;
            slot_m_q       <= slot_m_d;
            slot_n_q       <= slot_n_d;
            slot_addr_q    <= slot_addr_d;
            slot_stamp_q   <= slot_stamp_d;
            bump_q         <= bump_d;
            seq_q          <= seq_d;
            req_m_q        <= req_m_d;
            req_n_q        <= req_n_d;
            elems_q        <= elems_d;
            scan_idx_q     <= scan_idx_d;
            same_cnt_q     <= same_cnt_d;
            oldest_idx_q   <= oldest_idx_d;
            oldest_age_q   <= oldest_age_d;
            oldest_found_q <= oldest_found_d;
            free_idx_q     <= free_idx_d;
            free_found_q   <= free_found_d;
            pend_q         <= pend_d;
            pend_slot_q    <= pend_slot_d;
            pend_m_q       <= pend_m_d;
            pend_n_q       <= pend_n_d;
            pend_addr_q    <= pend_addr_d;
            alloc_valid_q  <= alloc_valid_d;
            alloc_fail_q   <= alloc_fail_d;
            alloc_slot_q   <= alloc_slot_d;
            alloc_addr_q   <= alloc_addr_d;
            err_q          <= err_d;
        end
    end

    // Lookup and status registers; clear_all snaps them to reset values at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q   <= 1'b0;
            rd_m_q       <= '0;
            rd_n_q       <= '0;
            rd_addr_q    <= '0;
            slot_count_q <= '0;
            free_words_q <= DEPTH_W;
        end else if (clear_all) begin
            rd_valid_q   <= 1'b0;
            rd_m_q       <= '0;
            rd_n_q       <= '0;
            rd_addr_q    <= '0;
            slot_count_q <= '0;
            free_words_q <= DEPTH_W;
        end else begin
            rd_valid_q   <= (slot_state_q[rd_slot] == SLOT_VALID);
            rd_m_q       <= (slot_state_q[rd_slot] == SLOT_VALID) ? slot_m_q[rd_slot] : '0;
            rd_n_q       <= (slot_state_q[rd_slot] == SLOT_VALID) ? slot_n_q[rd_slot] : '0;
            rd_addr_q    <= (slot_state_q[rd_slot] == SLOT_VALID) ? slot_addr_q[rd_slot] : '0;
            slot_count_q <= valid_cnt;
            free_words_q <= DEPTH_W - bump_q;
        end
    end

    assign alloc_valid = alloc_valid_q;
    assign alloc_fail  = alloc_fail_q;
    assign alloc_slot  = alloc_slot_q;
    assign alloc_addr  = alloc_addr_q;
    assign rd_valid    = rd_valid_q;
    assign rd_m        = rd_m_q;
    assign rd_n        = rd_n_q;
    assign rd_addr     = rd_addr_q;
    assign slot_count  = slot_count_q;
    assign free_words  = free_words_q;
    assign error_code  = err_q;

endmodule

// File: tb/tb_matrix_slot_manager.sv
// Scoreboard bench for matrix_slot_manager: a table-level reference model predicts
// each grant/refusal; a negedge monitor pops and compares every alloc pulse.
module tb_matrix_slot_manager;

    localparam int AW    = 11;
    localparam int DEPTH = 300;   // small depth so memory exhaustion is reachable

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    cfg = '0;
    logic          alloc_req = 1'b0;
    logic [4:0]    alloc_m = '0, alloc_n = '0;
    logic          alloc_valid, alloc_fail;
    logic [3:0]    alloc_slot;
    logic [AW-1:0] alloc_addr;
    logic          commit_req = 1'b0;
    logic [3:0]    commit_slot = '0;
    logic [4:0]    commit_m = '0, commit_n = '0;
    logic [AW-1:0] commit_addr = '0;
    logic          clear_all = 1'b0;
    logic [3:0]    rd_slot = '0;
    logic          rd_valid;
    logic [4:0]    rd_m, rd_n, slot_count;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   free_words;
    logic [3:0]    error_code;

    always #5 clk = ~clk;

    matrix_slot_manager #(.ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .SEQ_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .config_max_per_dim(cfg),
        .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n),
        .alloc_valid(alloc_valid), .alloc_fail(alloc_fail),
        .alloc_slot(alloc_slot), .alloc_addr(alloc_addr),
        .commit_req(commit_req), .commit_slot(commit_slot), .commit_m(commit_m),
        .commit_n(commit_n), .commit_addr(commit_addr), .clear_all(clear_all),
        .rd_slot(rd_slot), .rd_valid(rd_valid), .rd_m(rd_m), .rd_n(rd_n),
        .rd_addr(rd_addr), .slot_count(slot_count), .free_words(free_words),
        .error_code(error_code)
    );

    int errors = 0;
    int checks = 0;

    typedef struct { bit fail; int slot; int addr; } exp_t;
    exp_t exp_q[$];

    // Reference model: 0 free, 1 reserved, 2 valid
    int st[16], mm[16], nn[16], ad[16], stamp[16];
    int res_m[16], res_n[16];
    int m_bump = 0, m_seq = 0, m_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            st[i] = 0; mm[i] = 0; nn[i] = 0; ad[i] = 0; stamp[i] = 0;
        end
        m_bump = 0; m_seq = 0; m_err = 0;
    endtask

    task automatic model_commit(input int s, input int m, input int n, input int a);
        if (st[s] == 1) begin
            st[s] = 2; mm[s] = m; nn[s] = n; ad[s] = a; stamp[s] = m_seq; m_seq++;
        end else begin
            m_err = 2;
        end
    endtask

    task automatic model_alloc(input int m, input int n, input int c,
                               output bit fail, output int slot, output int addr);
        int same, old, oldage, fr, age;
        same = 0; old = -1; oldage = -1; fr = -1;
        fail = 1'b0; slot = 0; addr = 0;
        for (int i = 0; i < 16; i++) begin
            if (st[i] == 2 && mm[i] == m && nn[i] == n) begin
                same++;
                age = (m_seq - stamp[i]) & 16'hFFFF;
                if (age > oldage) begin oldage = age; old = i; end
            end
            if (st[i] == 0 && fr < 0) fr = i;
        end
        if (c != 0 && same >= c) begin
            slot = old; addr = ad[old]; st[old] = 1;
        end else if (fr >= 0 && m_bump + m * n <= DEPTH) begin
            slot = fr; addr = m_bump; ad[fr] = m_bump; st[fr] = 1; m_bump += m * n;
        end else begin
            fail = 1'b1;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (alloc_valid || alloc_fail) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_pulse: got valid=%0d fail=%0d expected no pulse",
                         alloc_valid, alloc_fail);
            end else begin
                e = exp_q.pop_front();
                chk("alloc_valid", int'(alloc_valid), int'(!e.fail));
                chk("alloc_fail", int'(alloc_fail), int'(e.fail));
                if (!e.fail) begin
                    chk("alloc_slot", int'(alloc_slot), e.slot);
                    chk("alloc_addr", int'(alloc_addr), e.addr);
                end
            end
        end
    end

    task automatic drive_commit(input int s, input int m, input int n, input int a);
        commit_req = 1'b1; commit_slot = 4'(s); commit_m = 5'(m); commit_n = 5'(n);
        commit_addr = AW'(a);
        model_commit(s, m, n, a);
        @(negedge clk);
        commit_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic commit_reserved(input int s);
        drive_commit(s, res_m[s], res_n[s], ad[s]);
    endtask

    task automatic drive_clear();
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    // pend_slot >= 0 commits that reserved slot mid-scan; dbl adds a second, dropped commit;
    // abort_at > 0 pulses clear_all in that scan cycle and lets the request restart.
    task automatic do_alloc(input int m, input int n, input int c,
                            input int pend_slot, input bit dbl, input int abort_at);
        bit f; int s, a, cnt;
        cfg = 3'(c); alloc_m = 5'(m); alloc_n = 5'(n);
        if (abort_at > 0) begin
            alloc_req = 1'b1;
            repeat (abort_at) @(negedge clk);
            clear_all = 1'b1;
            @(negedge clk);
            clear_all = 1'b0;
            model_clear();
            chk("clr_slot_count", int'(slot_count), 0);
            chk("clr_free_words", int'(free_words), DEPTH);
            chk("clr_error_code", int'(error_code), 0);
        end
        model_alloc(m, n, c, f, s, a);
        exp_q.push_back('{f, s, a});
        alloc_req = 1'b1;
        cnt = 0;
        while (cnt < 40) begin
            @(negedge clk);
            cnt++;
            commit_req = 1'b0;
            if (alloc_valid || alloc_fail) break;
            if (pend_slot >= 0 && (cnt == 3 || (dbl && cnt == 5))) begin
                commit_req = 1'b1; commit_slot = 4'(pend_slot);
                commit_m = 5'(res_m[pend_slot]); commit_n = 5'(res_n[pend_slot]);
                commit_addr = AW'(ad[pend_slot]);
                if (cnt == 3) model_commit(pend_slot, res_m[pend_slot], res_n[pend_slot], ad[pend_slot]);
                else m_err = 2;
            end
        end
        chk("alloc_latency", cnt, 18);
        if (f) begin
            repeat (4) @(negedge clk);
            chk("fail_hold_err", int'(error_code), 1);
            m_err = 1;
        end else begin
            res_m[s] = m; res_n[s] = n; m_err = 0;
        end
        alloc_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_state();
        int vc;
        repeat (2) @(negedge clk);
        vc = 0;
        for (int i = 0; i < 16; i++) if (st[i] == 2) vc++;
        chk("slot_count", int'(slot_count), vc);
        chk("free_words", int'(free_words), DEPTH - m_bump);
        chk("error_code", int'(error_code), m_err);
        for (int i = 0; i < 16; i++) begin
            rd_slot = 4'(i);
            @(negedge clk);
            chk("rd_valid", int'(rd_valid), int'(st[i] == 2));
            chk("rd_m", int'(rd_m), (st[i] == 2) ? mm[i] : 0);
            chk("rd_n", int'(rd_n), (st[i] == 2) ? nn[i] : 0);
            chk("rd_addr", int'(rd_addr), (st[i] == 2) ? ad[i] : 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, q[$];
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_alloc_valid", int'(alloc_valid), 0);
        chk("rst_alloc_fail", int'(alloc_fail), 0);
        chk("rst_alloc_slot", int'(alloc_slot), 0);
        chk("rst_alloc_addr", int'(alloc_addr), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_slot_count", int'(slot_count), 0);
        chk("rst_free_words", int'(free_words), DEPTH);
        chk("rst_error_code", int'(error_code), 0);

        // Sequential bump allocation
        do_alloc(3, 4, 0, -1, 0, 0);
        chk("first_slot_held", int'(alloc_slot), 0);
        chk("first_free_words", int'(free_words), DEPTH - 12);
        commit_reserved(0);
        check_state();
        do_alloc(2, 2, 0, -1, 0, 0);
        chk("second_addr_held", int'(alloc_addr), 12);
        commit_reserved(1);
        do_alloc(5, 5, 0, -1, 0, 0);
        commit_reserved(2);
        check_state();
        chk("bump_41", int'(free_words), DEPTH - 41);

        // Per-dimension limit reuses the oldest slot
        drive_clear();
        do_alloc(2, 2, 2, -1, 0, 0); commit_reserved(0);
        do_alloc(2, 2, 2, -1, 0, 0); commit_reserved(1);
        do_alloc(2, 2, 2, -1, 0, 0);
        chk("reuse_slot0", int'(alloc_slot), 0);
        commit_reserved(0);
        do_alloc(2, 2, 2, -1, 0, 0);
        chk("reuse_slot1", int'(alloc_slot), 1);
        commit_reserved(1);
        check_state();
        chk("reuse_bump", int'(free_words), DEPTH - 8);

        // Memory exhaustion and bad commit
        drive_clear();
        do_alloc(16, 16, 0, -1, 0, 0);
        do_alloc(8, 8, 0, -1, 0, 0);
        check_state();
        drive_commit(5, 1, 1, 0);
        check_state();

        // Commit deferred during a scan, second one dropped
        drive_clear();
        do_alloc(2, 2, 0, -1, 0, 0);
        do_alloc(3, 3, 0, 0, 1, 0);
        check_state();

        // clear_all mid-scan with request held
        commit_reserved(1);
        do_alloc(2, 3, 0, -1, 0, 7);
        chk("restart_slot", int'(alloc_slot), 0);
        chk("restart_addr", int'(alloc_addr), 0);
        commit_reserved(0);
        check_state();

        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 9);
            q.delete();
            for (int i = 0; i < 16; i++) if (st[i] == 1) q.push_back(i);
            if (op <= 4) begin
                if ($urandom_range(0, 7) == 0)
                    do_alloc(16, 16, $urandom_range(0, 3), -1, 0, 0);
                else
                    do_alloc($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 3), -1, 0, 0);
            end else if (op <= 7) begin
                if (q.size() > 0 && $urandom_range(0, 3) != 0)
                    commit_reserved(q[$urandom_range(0, q.size() - 1)]);
                else
                    drive_commit($urandom_range(0, 15), $urandom_range(1, 16), $urandom_range(1, 16), $urandom_range(0, 255));
            end else if (op == 8) begin
                check_state();
            end else if ($urandom_range(0, 3) == 0) begin
                drive_clear();
            end else begin
                do_alloc($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 3),
                         (q.size() > 0) ? q[0] : -1, 1'($urandom_range(0, 1)), 0);
            end
        end
        check_state();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
